// File: rtl/event_pkg.sv
// Shared types and constants for the event arbiter and the event FIFO it feeds.
package event_pkg;

  localparam int EVT_W     = 9;
  localparam int N_SRC_DEF = 4;
  localparam int N_SRC_MAX = 8;

  typedef logic [EVT_W-1:0] evt_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: round-robin from ptr+1, or fixed priority with
// index 0 highest.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          prio_mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  int s_idx;

  always_comb begin
    index = '0;
    s_idx = 0;
    any   = |req;
    if (prio_mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) index = IW'(i);
      end
    end else begin
      // Walk the search order backwards so the last hit is the first in order.
      for (int k = N; k >= 1; k--) begin
        s_idx = int'(ptr) + k;
        if (s_idx >= N) s_idx = s_idx - N;
        if (req[s_idx]) index = IW'(s_idx);
      end
    end
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (index == IW'(i));
    end
  end

endmodule

// File: rtl/event_arbiter.sv
// Arbitrates N_SRC event requesters into a single event FIFO write port and
// counts events discarded from disabled sources.
module event_arbiter #(
  parameter int N_SRC = event_pkg::N_SRC_DEF,
  parameter int EVT_W = event_pkg::EVT_W,
  localparam int IW   = $clog2(N_SRC)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*EVT_W-1:0] src_data,
  output logic [N_SRC-1:0]       src_ready,
  input  logic [N_SRC-1:0]       src_en,
  input  logic                   prio_mode,
  input  logic                   fifo_full,
  input  logic                   fifo_afull,
  output logic                   wr_en,
  output logic [EVT_W-1:0]       data_out,
  output logic [IW-1:0]          grant_id,
  output logic [15:0]            drop_cnt
);

  import event_pkg::popcount8;

  logic             wr_en_q, wr_en_d;
  logic [EVT_W-1:0] data_q, data_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]      drop_q, drop_d;

  logic             space_ok;
  logic             any_req;
  logic             do_grant;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] drop_v;
  logic [N_SRC-1:0] grant_raw;
  logic [N_SRC-1:0] grant;
  logic [IW-1:0]    gidx;
  logic [EVT_W-1:0] sel_data;
  logic [7:0]       drop_ext;
  logic [16:0]      drop_sum;

  // The afull term covers the write already registered but not yet in the FIFO.
  assign space_ok = !fifo_full && !(wr_en_q && fifo_afull);
  assign elig     = src_valid & src_en;
  assign drop_v   = src_valid & ~src_en;

  rr_arbiter #(
    .N  (N_SRC),
    .IW (IW)
  ) u_rr_arbiter (
    .req       (elig),
    .ptr       (rr_ptr_q),
    .prio_mode (prio_mode),
    .grant     (grant_raw),
    .index     (gidx),
    .any       (any_req)
  );

  assign do_grant  = space_ok && any_req;
  assign grant     = space_ok ? grant_raw : '0;
  assign src_ready = aresetn ? (grant | ~src_en) : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx == IW'(i)) sel_data = src_data[i*EVT_W +: EVT_W];
    end
  end

  always_comb begin
    drop_ext = 8'(drop_v);
    drop_sum = {1'b0, drop_q} + {13'b0, popcount8(drop_ext)};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    wr_en_d  = do_grant;
    data_d   = data_q;
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr_q;
    if (do_grant) begin
      data_d   = sel_data;
      gid_d    = gidx;
      rr_ptr_d = gidx;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      rr_ptr_q <= IW'(N_SRC - 1);
      drop_q   <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign data_out = data_q;
  assign grant_id = gid_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model with a FIFO.
module tb_event_arbiter;

  localparam int N = 4;
  localparam int W = 9;
  localparam int D = 4;

  logic             aclk;
  logic             aresetn;
  logic [N-1:0]     src_valid;
  logic [N*W-1:0]   src_data;
  logic [N-1:0]     src_ready;
  logic [N-1:0]     src_en;
  logic             prio_mode;
  logic             fifo_full;
  logic             fifo_afull;
  logic             wr_en;
  logic [W-1:0]     data_out;
  logic [1:0]       grant_id;
  logic [15:0]      drop_cnt;

  logic [W-1:0]     sd [N];

  event_arbiter #(.N_SRC(N), .EVT_W(W)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .src_en     (src_en),
    .prio_mode  (prio_mode),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .grant_id   (grant_id),
    .drop_cnt   (drop_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = sd[i];
  end

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  int         m_ptr;
  bit         m_wr;
  int         m_data;
  int         m_gid;
  int         m_drop;
  bit         use_fifo;
  bit         rd_en;
  int         overflow;
  int         fifo_q[$];
  int         exp_q[$];
  bit [N-1:0] last_rdy;
  logic [N-1:0] dut_rdy;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [N-1:0] el, input bit pm, input int ptr);
    if (pm) begin
      for (int i = 0; i < N; i++) if (el[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (el[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int popc(input bit [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_wr = 0; m_data = 0; m_gid = 0; m_drop = 0;
    overflow = 0;
    fifo_q.delete();
    exp_q.delete();
    last_rdy = '0;
  endtask

  // Inputs are already applied; checks ready, clocks once, checks outputs.
  task automatic run_cycle();
    bit [N-1:0] el, exp_rdy;
    bit         sp, pre_wr;
    int         g, pre_data, a, e;
    #1;
    sp = !fifo_full && !(m_wr && fifo_afull);
    el = src_valid & src_en;
    g  = sp ? pick(el, prio_mode, m_ptr) : -1;
    exp_rdy = ~src_en;
    if (g >= 0) exp_rdy[g] = 1'b1;
    dut_rdy = src_ready;
    chk("src_ready", src_ready, exp_rdy);
    last_rdy = exp_rdy;
    pre_wr   = wr_en;
    pre_data = int'(data_out);
    if (use_fifo) chk("wr_while_full", wr_en & fifo_full, 0);
    @(posedge aclk);
    if (use_fifo) begin
      if (rd_en && fifo_q.size() > 0) begin
        a = fifo_q.pop_front();
        e = exp_q.pop_front();
        chk("fifo_pop", a, e);
      end
      if (pre_wr) begin
        if (fifo_q.size() >= D) overflow++;
        else fifo_q.push_back(pre_data);
      end
      if (m_wr) exp_q.push_back(m_data);
    end
    m_drop += popc(src_valid & ~src_en);
    if (m_drop > 65535) m_drop = 65535;
    if (g >= 0) begin
      m_wr = 1; m_data = int'(sd[g]); m_gid = g; m_ptr = g;
    end else begin
      m_wr = 0;
    end
    #1;
    chk("wr_en", wr_en, m_wr);
    chk("data_out", data_out, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("drop_cnt", drop_cnt, m_drop);
    if (use_fifo) begin
      fifo_full  = (fifo_q.size() >= D);
      fifo_afull = (fifo_q.size() >= D - 1);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    src_valid = '1; src_en = '0; prio_mode = 0;
    fifo_full = 0; fifo_afull = 0; rd_en = 0;
    for (int i = 0; i < N; i++) sd[i] = '0;
    #1;
    chk("rst_ready", src_ready, 0);
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data", data_out, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ready_hold", src_ready, 0);
    @(negedge aclk);
    src_valid = '0; src_en = '1;
    aresetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] en;
    logic         pm;
    logic         full;
    logic         afull;
    logic [N-1:0] rdy;
    logic         wr;
    logic [W-1:0] data;
    int           gid;
    int           drop;
  } vec_t;

  vec_t tbl[13];

  initial begin
    //           v        en       pm  full afull rdy      wr  data    gid drop
    tbl[0]  = '{4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 1, 9'h001, 0, 0};
    tbl[1]  = '{4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 1, 9'h002, 1, 0};
    tbl[2]  = '{4'b1111, 4'b1111, 0, 0, 0, 4'b0100, 1, 9'h003, 2, 0};
    tbl[3]  = '{4'b1111, 4'b1111, 0, 0, 0, 4'b1000, 1, 9'h004, 3, 0};
    tbl[4]  = '{4'b0101, 4'b1111, 1, 0, 0, 4'b0001, 1, 9'h001, 0, 0};
    tbl[5]  = '{4'b0101, 4'b1111, 1, 0, 0, 4'b0001, 1, 9'h001, 0, 0};
    tbl[6]  = '{4'b0101, 4'b1111, 1, 1, 0, 4'b0000, 0, 9'h001, 0, 0};
    tbl[7]  = '{4'b0101, 4'b1111, 1, 0, 1, 4'b0001, 1, 9'h001, 0, 0};
    tbl[8]  = '{4'b0101, 4'b1111, 1, 0, 1, 4'b0000, 0, 9'h001, 0, 0};
    tbl[9]  = '{4'b0001, 4'b1110, 0, 0, 0, 4'b0001, 0, 9'h001, 0, 1};
    tbl[10] = '{4'b1111, 4'b1110, 0, 0, 0, 4'b0011, 1, 9'h002, 1, 2};
    tbl[11] = '{4'b1010, 4'b1111, 0, 0, 0, 4'b1000, 1, 9'h004, 3, 2};
    tbl[12] = '{4'b1111, 4'b1111, 1, 0, 0, 4'b0001, 1, 9'h001, 0, 2};

    aresetn = 1'b0;
    use_fifo = 0;
    model_reset();

    // directed vector table
    do_reset();
    for (int i = 0; i < N; i++) sd[i] = W'(i + 1);
    for (int t = 0; t < 13; t++) begin
      src_valid = tbl[t].v; src_en = tbl[t].en; prio_mode = tbl[t].pm;
      fifo_full = tbl[t].full; fifo_afull = tbl[t].afull;
      run_cycle();
      chk($sformatf("tbl%0d_ready", t), dut_rdy, tbl[t].rdy);
      chk($sformatf("tbl%0d_wr", t), wr_en, tbl[t].wr);
      chk($sformatf("tbl%0d_data", t), data_out, tbl[t].data);
      chk($sformatf("tbl%0d_gid", t), grant_id, tbl[t].gid);
      chk($sformatf("tbl%0d_drop", t), drop_cnt, tbl[t].drop);
    end

    // disabled source: always ready, dropped, never written
    do_reset();
    sd[0] = 9'h001; src_en = 4'b1110; src_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      chk("dis_ready0", dut_rdy[0], 1);
      chk("dis_no_wr", wr_en, 0);
    end
    chk("dis_drop10", drop_cnt, 10);

    // reset during a registered write; first grant afterwards is source 0
    do_reset();
    for (int i = 0; i < N; i++) sd[i] = W'(i + 1);
    src_valid = 4'b1111;
    run_cycle();
    chk("mid_pre_wr", wr_en, 1);
    aresetn = 1'b0;
    #1;
    chk("mid_wr_cleared", wr_en, 0);
    chk("mid_ready_zero", src_ready, 0);
    chk("mid_data_cleared", data_out, 0);
    @(negedge aclk);
    model_reset();
    aresetn = 1'b1;
    src_valid = 4'b1111;
    run_cycle();
    chk("post_rst_ready", dut_rdy, 4'b0001);
    chk("post_rst_gid", grant_id, 0);
    chk("post_rst_data", data_out, 9'h001);

    // single source into a FIFO with no reads: fill without overflow
    do_reset();
    use_fifo = 1; rd_en = 0;
    sd[0] = 9'h10F; src_valid = 4'b0001;
    repeat (12) run_cycle();
    chk("fill_size", fifo_q.size(), D);
    chk("fill_full", fifo_full, 1);
    chk("fill_overflow", overflow, 0);
    for (int i = 0; i < fifo_q.size(); i++) chk("fill_entry", fifo_q[i], 9'h10F);
    src_valid = '0; rd_en = 1;
    repeat (6) run_cycle();
    chk("drain_empty", fifo_q.size(), 0);

    // randomized traffic against the model with FIFO back-pressure
    do_reset();
    use_fifo = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0)
        for (int i = 0; i < N; i++) src_en[i] = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 39) == 0) prio_mode = ~prio_mode;
      rd_en = ($urandom_range(0, 99) < 45);
      for (int i = 0; i < N; i++) begin
        if (!(src_valid[i] && !last_rdy[i])) begin
          src_valid[i] = ($urandom_range(0, 99) < 55);
          sd[i] = W'($urandom_range(0, 511));
        end
      end
      run_cycle();
    end
    chk("rand_overflow", overflow, 0);

    // drop counter saturation
    do_reset();
    use_fifo = 0;
    src_en = '0; src_valid = 4'b1111;
    repeat (16383) run_cycle();
    src_valid = 4'b0011;
    run_cycle();
    chk("sat_fffe", drop_cnt, 16'hFFFE);
    src_valid = 4'b0111;
    run_cycle();
    chk("sat_ffff", drop_cnt, 16'hFFFF);
    src_valid = 4'b1111;
    run_cycle();
    chk("sat_hold", drop_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
